hazard_sequencer: RTL
=====================

Name: hazard_sequencer

Overview:
- Central stall/flush controller for the 5-stage pipeline.
- Each cycle it decides which pipeline registers (IF_ID, ID_EX, EX_MEM, MEM_WB) and the PC advance, hold or take a bubble.
- Sources: instruction/data cache waits, load-use hazards the forwarding unit cannot cover, MEM-stage branch/jump redirects, and halt.
- Tracks multi-cycle conditions in a small FSM and keeps saturating performance counters.

Parameters:
REG_W, 5, register index width (regbits_t)
CNT_W, 16, width of performance counters

Ports:
CLK  input  1  clock
RST  input  1  synchronous active-high reset
ihit  input  1  instruction fetch complete this cycle
dhit  input  1  data access complete this cycle
dmem_req_EX_MEM  input  1  instruction in MEM stage reads or writes memory
load_ID_EX  input  1  instruction in EX is LW/LL
WEN_ID_EX  input  1  instruction in EX writes register file
reg_wr_ID_EX  input  REG_W  destination register of EX instruction
rs_IF_ID  input  REG_W  rs of ID instruction
rt_IF_ID  input  REG_W  rt of ID instruction
uses_rt_IF_ID  input  1  ID instruction reads rt
redirect_MEM  input  1  taken branch/jump resolved in MEM
halt_MEM_WB  input  1  HALT reached WB
pc_en  output  1  PC update enable
IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en  output  1 each  register enables
IF_ID_flush, ID_EX_flush, EX_MEM_flush  output  1 each  load bubble (synchronous clear) on next edge
halt_out  output  1  sticky halted flag
state  output  2  RUN=0, LDSTALL=1, DWAIT=2, HALT=3
stall_cycles  output  CNT_W  saturating count of stall cycles
redirects  output  CNT_W  saturating count of redirects

Behaviour:
- Reset values (next edge with RST=1): state=RUN, halt_out=0, counters=0.
- While RST=1, all combinational enables and flushes are forced to 0.

Derived signals:
- dstall = dmem_req_EX_MEM & ~dhit.
- lu = load_ID_EX & WEN_ID_EX & (reg_wr_ID_EX != 0) & ((reg_wr_ID_EX == rs_IF_ID) | (uses_rt_IF_ID & reg_wr_ID_EX == rt_IF_ID)).

Output decision (combinational, Mealy), in priority order, for state RUN/LDSTALL/DWAIT:
1. dstall: all enables and pc_en = 0, no flush; next state = DWAIT.
2. halt_MEM_WB: MEM_WB_en=1, everything else 0; next state = HALT.
3. redirect_MEM: pc_en=1 regardless of ihit; IF_ID_flush = ID_EX_flush = EX_MEM_flush = 1; MEM_WB_en=1; redirects++; next state = RUN.
4. lu, evaluated in RUN only (masked in LDSTALL): pc_en=0, IF_ID_en=0, ID_EX_flush=1, EX_MEM_en = MEM_WB_en = 1; next state = LDSTALL.
5. ~ihit: pc_en=0, IF_ID_flush=1, ID_EX_en = EX_MEM_en = MEM_WB_en = 1; next state = RUN.
6. Otherwise: all enables = 1, no flush; next state = RUN.

Per-state rules:
- A flush overrides the matching enable; flushed registers load a NOP with all control signals deasserted.
- DWAIT exits on the dhit cycle; that cycle is evaluated from rule 2 downward.
- LDSTALL always lasts exactly one non-dstall cycle.
- HALT: all outputs 0, halt_out=1 (registered, asserted the cycle after entry), state sticky until RST.

Counters:
- stall_cycles increments in any non-HALT, non-reset cycle with pc_en=0, except when a redirect is taken.
- Both counters saturate at 2^CNT_W-1 with no wrap.

Simultaneous events and reset:
- redirect + lu: redirect wins; no bubble is inserted and state goes to RUN.
- halt + redirect: halt wins.
- RST asserted mid-DWAIT or in HALT: state returns to RUN on that edge.

Test Plan:
- Load-use: LW writing r5 in EX, ID reads rs=5, ihit=1 -> one cycle pc_en=0, IF_ID_en=0, ID_EX_flush=1, state=1; next cycle all enables 1, state=0, stall_cycles=1.
- Data miss: dmem_req=1, dhit=0 for 3 cycles then 1 -> 3 cycles all enables 0, state=2; dhit cycle all enables 1; stall_cycles=3.
- Redirect during ifetch miss and simultaneous lu: redirect_MEM=1, ihit=0, lu=1 -> pc_en=1, three flushes=1, MEM_WB_en=1, redirects=1, state=0, no bubble.
- Halt: halt_MEM_WB=1 -> next cycle state=3, halt_out=1; subsequent ihit/redirect inputs keep all outputs 0; RST -> state=0, halt_out=0.
- Register 0 and rt gating: reg_wr_ID_EX=0 with rs=0, and uses_rt=0 with rt match -> no stall.
- Saturation with CNT_W=4: hold ihit=0 for 20 cycles -> stall_cycles stops at 15.

Source files
------------

// File: rtl/hazard_sequencer.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Registered FSM state plus saturating stall and redirect counters.
module hazard_sequencer #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dmem_req_EX_MEM,
  input  logic             load_ID_EX,
  input  logic             WEN_ID_EX,
  input  logic [REG_W-1:0] reg_wr_ID_EX,
  input  logic [REG_W-1:0] rs_IF_ID,
  input  logic [REG_W-1:0] rt_IF_ID,
  input  logic             uses_rt_IF_ID,
  input  logic             redirect_MEM,
  input  logic             halt_MEM_WB,
  output logic             pc_en,
  output logic             IF_ID_en,
  output logic             ID_EX_en,
  output logic             EX_MEM_en,
  output logic             MEM_WB_en,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             EX_MEM_flush,
  output logic             halt_out,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] redirects
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    DWAIT   = 2'd2,
    HALT    = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_halt;
  logic [CNT_W-1:0] r_stall;
  logic [CNT_W-1:0] r_redir;

  logic w_dstall;
  logic w_hit_rs;
  logic w_hit_rt;
  logic w_lu;
  logic w_redir_take;
  logic w_stall_inc;

  assign w_dstall = dmem_req_EX_MEM & ~dhit;
  assign w_hit_rs = reg_wr_ID_EX == rs_IF_ID;
  assign w_hit_rt = uses_rt_IF_ID &
                    (reg_wr_ID_EX == rt_IF_ID);
  assign w_lu     = load_ID_EX & WEN_ID_EX &
                    (reg_wr_ID_EX != '0) &
                    (w_hit_rs | w_hit_rt);

  always_comb begin
    pc_en        = 1'b0;
    IF_ID_en     = 1'b0;
    ID_EX_en     = 1'b0;
    EX_MEM_en    = 1'b0;
    MEM_WB_en    = 1'b0;
    IF_ID_flush  = 1'b0;
    ID_EX_flush  = 1'b0;
    EX_MEM_flush = 1'b0;
    w_redir_take = 1'b0;
    w_next       = r_state;
    if (RST) begin
      w_next = RUN;
    end else if (r_state == HALT) begin
      w_next = HALT;
    end else if (w_dstall) begin
      w_next = DWAIT;
    end else if (halt_MEM_WB) begin
      MEM_WB_en = 1'b1;
      w_next    = HALT;
    end else if (redirect_MEM) begin
      pc_en        = 1'b1;
      MEM_WB_en    = 1'b1;
      IF_ID_flush  = 1'b1;
      ID_EX_flush  = 1'b1;
      EX_MEM_flush = 1'b1;
      w_redir_take = 1'b1;
      w_next       = RUN;
    end else if (w_lu && r_state == RUN) begin
      ID_EX_flush = 1'b1;
      EX_MEM_en   = 1'b1;
      MEM_WB_en   = 1'b1;
      w_next      = LDSTALL;
    end else if (!ihit) begin
      IF_ID_flush = 1'b1;
      ID_EX_en    = 1'b1;
      EX_MEM_en   = 1'b1;
      MEM_WB_en   = 1'b1;
      w_next      = RUN;
    end else begin
      pc_en     = 1'b1;
      IF_ID_en  = 1'b1;
      ID_EX_en  = 1'b1;
      EX_MEM_en = 1'b1;
      MEM_WB_en = 1'b1;
      w_next    = RUN;
    end
  end

  // A redirect always advances the PC, so it never counts as a stall.
  assign w_stall_inc = !RST && r_state != HALT &&
                       !pc_en && !w_redir_take;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= RUN;
      r_halt  <= 1'b0;
      r_stall <= '0;
      r_redir <= '0;
    end else begin
      r_state <= w_next;
      if (w_next == HALT)
        r_halt <= 1'b1;
      if (w_stall_inc && r_stall != '1)
        r_stall <= r_stall + 1'b1;
      if (w_redir_take && r_redir != '1)
        r_redir <= r_redir + 1'b1;
    end
  end

  assign state        = r_state;
  assign halt_out     = r_halt;
  assign stall_cycles = r_stall;
  assign redirects    = r_redir;

endmodule
